lag_pl_buffer_bank: RTL
=======================

Name: lag_pl_buffer_bank

Overview:
- Next-generation physical-channel input buffer bank for the LAG router input port.
- N independent FIFOs with parametrised flit width, depth and bypass mode.
- Per-channel occupancy counts and registered credit return to the upstream router.
- Sticky overflow/underflow error flags.
- Sits between the link receiver and the input-port allocator/crossbar; replaces the fixed flag-only PL buffer array.

Parameters:
- n, 4, number of physical channels.
- size, 4, FIFO depth per channel in flits (>=2).
- width, 64, flit width in bits.
- bypass, 0, 1 = an empty FIFO presents a same-cycle pushed flit combinationally on data_out.
- cw, $clog2(size+1), occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- push  in  n  push[i] writes data_in slice i into FIFO i.
- pop  in  n  pop[i] removes the head of FIFO i at the clock edge.
- data_in  in  n*width  flit per channel; slice i = bits [i*width +: width].
- data_out  out  n*width  head flit per channel.
- valid  out  n  head of FIFO i is valid (non-empty, or bypass flit present).
- full  out  n  count[i]==size.
- nearly_full  out  n  count[i]>=size-1.
- count  out  n*cw  occupancy per channel.
- credit_out  out  n  one-cycle pulse per accepted pop.
- err_clr  in  1  synchronous clear of all sticky error flags.
- ovf_err  out  n  sticky: push attempted while full without pop.
- udf_err  out  n  sticky: pop attempted while not valid.

Behaviour:
- Reset, asynchronous, immediate:
  - All counts=0, read/write pointers=0; valid=0, full=0, nearly_full=0 (for size>=2).
  - credit_out=0, ovf_err=0, udf_err=0.
  - data_out is don't-care but must not be X-propagated into valid.
  - Reset mid-operation discards all stored flits; no credit pulses for discarded flits.
- Channels are fully independent; there are no cross-channel interactions.
- Storage per channel: circular buffer of size entries with rd/wr pointers.
  - Pointers wrap from size-1 to 0; size need not be a power of 2.
- Accepted push: push[i] && (!full[i] || pop_acc[i]).
- Accepted pop: pop_acc[i] = pop[i] && valid[i].
- Count update:
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged on both or neither.
  - Never exceeds size, never underflows.
- Push+pop while full: both accepted; count stays size; the new flit is written into the slot freed by the pop.
- Push while full without pop: flit dropped, storage unchanged, ovf_err[i] set next edge.
- Pop while !valid: ignored, udf_err[i] set next edge.
- err_clr has priority below a new error in the same cycle: a new error sets the flag even when err_clr=1.
- Latency, bypass=0:
  - Pushed flit appears on data_out/valid the cycle after the push edge.
  - valid[i] = count[i]!=0.
- Latency, bypass=1:
  - When count[i]==0 and push[i]=1: valid[i]=1 and data_out = data_in combinationally.
  - If pop[i] is also asserted, the flit passes through without being stored; count stays 0 and a credit is still returned.
  - Otherwise the flit is stored normally.
- credit_out[i] registered: asserted exactly one cycle after each accepted pop, for one cycle.
  - Back-to-back pops give back-to-back credits.
- full, nearly_full, valid (bypass=0) are derived from registered count; glitch-free.

Test Plan:
- Fill/drain, n=4, size=4, bypass=0: 4 pushes on ch2 (flits 0xA0..0xA3) -> count[2] 1,2,3,4; nearly_full at 3, full at 4. Then 4 pops -> data_out 0xA0..0xA3 in order, credit_out[2] pulses cycles+1, count returns 0, other channels untouched.
- Overflow: ch0 full, push 0xFF without pop -> flit dropped, count stays 4, ovf_err[0]=1 next cycle. Pop sequence still yields original 4 flits. err_clr=1 -> ovf_err[0]=0.
- Simultaneous push+pop when full: ch1 holds 0x10..0x13, push 0x14 + pop -> count 4, head 0x11; subsequent drain yields 0x11..0x14 (pointer wrap verified).
- Underflow: pop[3] on empty ch3 -> no state change, no credit, udf_err[3]=1 next cycle.
- Bypass: bypass=1, empty ch0, push 0x55 + pop same cycle -> data_out slice0=0x55 and valid[0]=1 combinationally, count stays 0, credit_out[0]=1 next cycle.
- Async reset mid-traffic: assert rst with ch0 count=3, off clock edge -> count, valid, full, credit_out, errors all 0 immediately; after release, push works from pointer 0.

Source files
------------

// File: rtl/lag_pl_buffer_bank.sv
// Physical-channel input buffer bank: n independent circular FIFOs with
// occupancy counts, registered credit return and sticky error flags.
module lag_pl_buffer_bank #(
    parameter int   n      = 4,
    parameter int   size   = 4,
    parameter int   width  = 64,
    parameter bit   bypass = 1'b0,
    localparam int  cw     = $clog2(size + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [n-1:0]         push,
    input  logic [n-1:0]         pop,
    input  logic [n*width-1:0]   data_in,
    output logic [n*width-1:0]   data_out,
    output logic [n-1:0]         valid,
    output logic [n-1:0]         full,
    output logic [n-1:0]         nearly_full,
    output logic [n*cw-1:0]      count,
    output logic [n-1:0]         credit_out,
    input  logic                 err_clr,
    output logic [n-1:0]         ovf_err,
    output logic [n-1:0]         udf_err
);

    localparam int             pw     = (size > 1) ? $clog2(size) : 1;
    localparam logic [pw-1:0]  c_last = pw'(size - 1);
    localparam logic [cw-1:0]  c_size = cw'(size);
    localparam logic [cw-1:0]  c_nf   = cw'(size - 1);

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [pw-1:0] f_inc(input logic [pw-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_ch
            logic [width-1:0] r_mem [size];
            logic [pw-1:0]    r_rd_ptr;
            logic [pw-1:0]    r_wr_ptr;
            logic [cw-1:0]    r_count;
            logic             r_credit;
            logic             r_ovf;
            logic             r_udf;

            logic [width-1:0] w_din;
            logic             w_empty;
            logic             w_full;
            logic             w_bypass;
            logic             w_valid;
            logic             w_pop_acc;
            logic             w_push_acc;
            logic             w_store;
            logic             w_take;

            assign w_din      = data_in[gi*width +: width];
            assign w_empty    = (r_count == '0);
            assign w_full     = (r_count == c_size);
            assign w_bypass   = (bypass != 1'b0) && w_empty && push[gi];
            assign w_valid    = !w_empty || w_bypass;
            assign w_pop_acc  = pop[gi] && w_valid;
            assign w_push_acc = push[gi] && (!w_full || w_pop_acc);
            // A bypassed flit that is popped in the same cycle never touches storage.
            assign w_store    = w_push_acc && !(w_bypass && w_pop_acc);
            assign w_take     = w_pop_acc && !w_bypass;

            always_ff @(posedge clk) begin
                if (w_store) begin
                    r_mem[r_wr_ptr] <= w_din;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                    r_credit <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_udf    <= 1'b0;
                end else begin
                    if (w_store) begin
                        r_wr_ptr <= f_inc(r_wr_ptr);
                    end
                    if (w_take) begin
                        r_rd_ptr <= f_inc(r_rd_ptr);
                    end
                    case ({w_store, w_take})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                    r_credit <= w_pop_acc;
                    // New errors win over a simultaneous clear.
                    r_ovf <= (r_ovf && !err_clr) || (push[gi] && w_full && !w_pop_acc);
                    r_udf <= (r_udf && !err_clr) || (pop[gi] && !w_valid);
                end
            end

            assign data_out[gi*width +: width] = w_bypass ? w_din : r_mem[r_rd_ptr];
            assign valid[gi]                   = w_valid;
            assign full[gi]                    = w_full;
            assign nearly_full[gi]             = (r_count >= c_nf);
            assign count[gi*cw +: cw]          = r_count;
            assign credit_out[gi]              = r_credit;
            assign ovf_err[gi]                 = r_ovf;
            assign udf_err[gi]                 = r_udf;
        end
    endgenerate

endmodule
